// File: rtl/cpu_pkg.sv
// cpu_pkg: constants shared by the CPU front-panel sequencer and its button
// debouncers. Phase codes, ID widths, register count and parameter defaults.
package cpu_pkg;

  localparam int PHASE_W  = 3;
  localparam int REG_ID_W = 4;
  localparam int NUM_REGS = 8;
  localparam int REG_ADDR_W = $clog2(NUM_REGS);

  localparam logic [PHASE_W-1:0] S_OP   = 3'd0;
  localparam logic [PHASE_W-1:0] S_R1   = 3'd1;
  localparam logic [PHASE_W-1:0] S_R2   = 3'd2;
  localparam logic [PHASE_W-1:0] S_EXEC = 3'd3;
  localparam logic [PHASE_W-1:0] S_WB   = 3'd4;

  localparam int unsigned             DEBOUNCE_DEFAULT     = 50000;
  localparam int unsigned             EXEC_LATENCY_DEFAULT = 2;
  localparam logic [REG_ADDR_W-1:0]   RESULT_REG_DEFAULT   = 3'd7;

  // Front-panel input is locked out while the datapath is executing.
  function automatic logic is_busy_phase(input logic [PHASE_W-1:0] phase);
    return (phase == S_EXEC) || (phase == S_WB);
  endfunction

endpackage

// File: rtl/button_debounce.sv
// button_debounce: 2-FF synchronizer plus stability down-counter for one
// raw active-low push button.
//   clock, reset_n : system clock, async active-low reset
//   raw_n          : raw button (0 = pressed)
//   level          : accepted (debounced) level, 1 = released
//   press          : one-cycle pulse on the accepted 1->0 transition
module button_debounce
  import cpu_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clock,
  input  logic reset_n,
  input  logic raw_n,
  output logic level,
  output logic press
);

  localparam logic [15:0] RELOAD = 16'(DEBOUNCE_CYCLES - 1);

  logic        sync1_q, sync2_q;
  logic        level_q, level_d;
  logic [15:0] cnt_q, cnt_d;

  // The counter reaches zero on the DEBOUNCE_CYCLES-th consecutive sample
  // that differs from the accepted level; that sample commits the change.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    press   = 1'b0;
    if (sync2_q == level_q) begin
      cnt_d = RELOAD;
    end else if (cnt_q == 16'd0) begin
      level_d = sync2_q;
      cnt_d   = RELOAD;
      press   = ~sync2_q;
    end else begin
      cnt_d = cnt_q - 16'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= RELOAD;
    end else begin
      sync1_q <= raw_n;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: front-panel controller for the 8-bit CPU datapath.
// Debounces the set/display buttons, walks opcode -> src1 -> src2 -> execute,
// latches the switch values, strobes the operation unit and then the result
// write-enable.
//   clock, reset_n          : system clock, async active-low reset
//   setButton, displayButton: raw active-low buttons
//   inputs                  : raw switches
//   Q                       : current phase
//   opCode, regID1, regID2  : latched selections
//   operate, result_we      : one-cycle strobes; result_addr is constant
//   show_value, bad_id, busy: display mode, rejected-ID pulse, lockout
//
// state  | meaning
// S_OP   | wait for set press, latch opcode
// S_R1   | wait for set press, latch first source ID (bit 3 must be 0)
// S_R2   | wait for set press, latch second source ID (bit 3 must be 0)
// S_EXEC | operate strobe, then wait EXEC_LATENCY cycles for the result
// S_WB   | one-cycle result write-enable, then back to S_OP
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned            DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int unsigned            EXEC_LATENCY    = EXEC_LATENCY_DEFAULT,
  parameter logic [REG_ADDR_W-1:0]  RESULT_REG      = RESULT_REG_DEFAULT
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  setButton,
  input  logic                  displayButton,
  input  logic [REG_ID_W-1:0]   inputs,
  output logic [PHASE_W-1:0]    Q,
  output logic [REG_ID_W-1:0]   opCode,
  output logic [REG_ID_W-1:0]   regID1,
  output logic [REG_ID_W-1:0]   regID2,
  output logic                  operate,
  output logic                  result_we,
  output logic [REG_ADDR_W-1:0] result_addr,
  output logic                  show_value,
  output logic                  bad_id,
  output logic                  busy
);

  logic set_level, set_press, disp_level, disp_press;
  logic unused_levels;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_set_db (
    .clock(clock), .reset_n(reset_n), .raw_n(setButton),
    .level(set_level), .press(set_press)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_disp_db (
    .clock(clock), .reset_n(reset_n), .raw_n(displayButton),
    .level(disp_level), .press(disp_press)
  );

  // Accepted levels are only needed by other front-panel consumers.
  assign unused_levels = set_level ^ disp_level;

  logic [PHASE_W-1:0]  state_q, state_d;
  logic [REG_ID_W-1:0] op_q, op_d, r1_q, r1_d, r2_q, r2_d;
  logic [7:0]          exec_cnt_q, exec_cnt_d;
  logic                show_q, show_d, bad_q, bad_d;
  logic                operate_q, operate_d, we_q, we_d, busy_q, busy_d;
  logic                set_p, disp_p;

  // Presses that land while busy are simply dropped, never queued.
  assign set_p  = set_press  & ~busy_q;
  assign disp_p = disp_press & ~busy_q;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    r1_d       = r1_q;
    r2_d       = r2_q;
    exec_cnt_d = exec_cnt_q;
    show_d     = show_q;
    bad_d      = 1'b0;
    case (state_q)
      S_OP: begin
        if (set_p) begin
          op_d    = inputs;
          state_d = S_R1;
        end
      end
      S_R1, S_R2: begin
        // A set press takes priority; a simultaneous display press is ignored.
        if (set_p) begin
          if (inputs[REG_ID_W-1]) begin
            bad_d = 1'b1;
          end else if (state_q == S_R1) begin
            r1_d    = inputs;
            state_d = S_R2;
          end else begin
            r2_d       = inputs;
            state_d    = S_EXEC;
            exec_cnt_d = 8'(EXEC_LATENCY);
          end
        end else if (disp_p) begin
          show_d = ~show_q;
        end
      end
      S_EXEC: begin
        if (exec_cnt_q == 8'd0) state_d = S_WB;
        else                    exec_cnt_d = exec_cnt_q - 8'd1;
      end
      S_WB:    state_d = S_OP;
      default: state_d = S_OP;
    endcase
    if (state_d != state_q) show_d = 1'b0;
  end

  assign operate_d = (state_d == S_EXEC) && (state_q != S_EXEC);
  assign we_d      = (state_d == S_WB)   && (state_q != S_WB);
  assign busy_d    = is_busy_phase(state_d);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_OP;
      op_q       <= '0;
      r1_q       <= '0;
      r2_q       <= '0;
      exec_cnt_q <= '0;
      show_q     <= 1'b0;
      bad_q      <= 1'b0;
      operate_q  <= 1'b0;
      we_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      r1_q       <= r1_d;
      r2_q       <= r2_d;
      exec_cnt_q <= exec_cnt_d;
      show_q     <= show_d;
      bad_q      <= bad_d;
      operate_q  <= operate_d;
      we_q       <= we_d;
      busy_q     <= busy_d;
    end
  end

  assign Q           = state_q;
  assign opCode      = op_q;
  assign regID1      = r1_q;
  assign regID2      = r2_q;
  assign operate     = operate_q;
  assign result_we   = we_q;
  assign result_addr = RESULT_REG;
  assign show_value  = show_q;
  assign bad_id      = bad_q;
  assign busy        = busy_q;

endmodule
